// File: rtl/fifo_drain.sv
// Read-side controller for a show-ahead FIFO: pops words into a 2-entry skid
// buffer and presents them on a registered valid/ready interface.
module fifo_drain #(
  parameter int w = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fifo_empty,
  input  logic [w-1:0] fifo_data,
  output logic         fifo_re,
  input  logic         flush,
  output logic         out_valid,
  output logic [w-1:0] out_data,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [w-1:0] r_head;
  logic [w-1:0] r_tail;
  logic [w-1:0] w_head_nxt;
  logic [w-1:0] w_tail_nxt;
  logic         w_load;
  logic         w_deq;

  // Pop decision looks only at registered occupancy, never at out_ready.
  assign fifo_re   = rst_n & ~fifo_empty & ~flush & (r_state != TWO);
  assign w_load    = fifo_re;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_head;
  assign w_deq     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_load) begin
            w_head_nxt  = fifo_data;
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          if (w_load && w_deq) begin
            w_head_nxt = fifo_data;
          end else if (w_load) begin
            w_tail_nxt  = fifo_data;
            w_state_nxt = TWO;
          end else if (w_deq) begin
            w_state_nxt = EMPTY;
          end
        end
        TWO: begin
          // No load can coincide here since fifo_re is low while full.
          if (w_deq) begin
            w_head_nxt  = r_tail;
            w_state_nxt = ONE;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

endmodule
